// File: rtl/ser_id_pkg.sv
// Shared types and bus-window constants for the serial ID/key reader.
// The window helper builds BA13..BA4 for a read of the 0x1000-0x1FFF window.
package ser_id_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DATA = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // BA13..BA12 select the device window, BA11..BA8 are always zero.
  localparam logic [1:0] SER_WIN_HI   = 2'b01;
  localparam logic [3:0] SER_WIN_MID  = 4'h0;
  localparam logic [3:0] SER_DATA_NIB = 4'h0;

  function automatic logic [9:0] ser_ba(input logic [3:0] nib);
    return {SER_WIN_HI, SER_WIN_MID, nib};
  endfunction

endpackage

// File: rtl/ser_rd_cycle.sv
// One bus read of the device window: address phase, strobe phases, gap phase.
// While go is low the phase counter parks at 0 and ba holds the last address.
module ser_rd_cycle
  import ser_id_pkg::*;
#(
  parameter int BUS_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic [3:0] nibble,
  output logic [9:0] ba,
  output logic       bstrb,
  output logic       sample,
  output logic       last
);

  localparam int              PH_W    = $clog2(BUS_CYC);
  localparam logic [PH_W-1:0] PH_SAMP = PH_W'(BUS_CYC - 2);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(BUS_CYC - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic [9:0]      ba_q, ba_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    phase_d = '0;
    ba_d    = ba_q;
    if (go) begin
      ba_d = ser_ba(nibble);
      if (phase_q != PH_LAST) phase_d = phase_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments only, and reset clears
  // every flop so a read interrupted by rst leaves nothing stale behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      ba_q    <= '0;
    end else begin
      phase_q <= phase_d;
      ba_q    <= ba_d;
    end
  end

  // Address is live in phase 0 so it is set up before the strobe rises.
  assign ba     = ba_d;
  assign bstrb  = go && (phase_q != '0) && (phase_q != PH_LAST);
  assign sample = go && (phase_q == PH_SAMP);
  assign last   = go && (phase_q == PH_LAST);

endmodule

// File: rtl/ser_id_rd.sv
// Serial ID/key reader: key preamble reads, then one read per data bit,
// assembled LSB first into a parallel word.
module ser_id_rd
  import ser_id_pkg::*;
#(
  parameter int KEY_LEN   = 4,
  parameter int DATA_BITS = 16,
  parameter int BUS_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [4*KEY_LEN-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [DATA_BITS-1:0] data,
  output logic [9:0]           ba,
  output logic                 br_w,
  output logic                 sser,
  output logic                 bstrb,
  input  logic                 sdrd
);

  localparam int MAX_N = (KEY_LEN > DATA_BITS) ? KEY_LEN : DATA_BITS;
  localparam int IDX_W = $clog2(MAX_N + 1);
  localparam logic [IDX_W-1:0] KEY_LAST  = IDX_W'(KEY_LEN - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*KEY_LEN-1:0] key_q, key_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 abort_q, abort_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic       go;
  logic [3:0] nibble;
  logic       rd_sample;
  logic       rd_last;
  logic       abort_hit;

  assign go        = (state_q == ST_KEY) || (state_q == ST_DATA);
  // The key register shifts down one nibble per key read, so the current
  // nibble is always in the low four bits.
  assign nibble    = (state_q == ST_KEY) ? key_q[3:0] : SER_DATA_NIB;
  assign abort_hit = abort_q || abort;

  ser_rd_cycle #(
    .BUS_CYC (BUS_CYC)
  ) u_rd_cycle (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .nibble (nibble),
    .ba     (ba),
    .bstrb  (bstrb),
    .sample (rd_sample),
    .last   (rd_last)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    key_d     = key_q;
    data_d    = data_q;
    abort_d   = abort_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        // A start that coincides with abort is dropped along with the abort.
        if (start && !abort) begin
          state_d   = ST_KEY;
          idx_d     = '0;
          key_d     = key;
          data_d    = '0;
          abort_d   = 1'b0;
          busy_d    = 1'b1;
          aborted_d = 1'b0;
        end
      end

      ST_KEY: begin
        abort_d = abort_hit;
        if (rd_last) begin
          key_d = key_q >> 4;
          if (abort_hit) begin
            state_d = ST_FIN;
          end else if (idx_q == KEY_LAST) begin
            state_d = ST_DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        abort_d = abort_hit;
        if (rd_sample) begin
          for (int i = 0; i < DATA_BITS; i++) begin
            if (idx_q == i[IDX_W-1:0]) data_d[i] = sdrd;
          end
        end
        if (rd_last) begin
          if (abort_hit || (idx_q == DATA_LAST)) begin
            state_d = ST_FIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      ST_FIN: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        aborted_d = abort_q;
        abort_d   = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      key_q     <= '0;
      data_q    <= '0;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      key_q     <= key_d;
      data_q    <= data_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign data    = data_q;
  assign br_w    = 1'b1;
  assign sser    = ~go;

endmodule
